// File: rtl/arb_mux_n_if.sv
// Bundle of channel-side and output-side handshake signals for arb_mux_n.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the inputs and consumes the output.
interface arb_mux_n_if #(
    parameter int WIDTH = 64,
    parameter int N     = 8,
    parameter int SW    = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SW-1:0]      force_sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SW-1:0]      out_chan;

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/arb_mux_n.sv
// N-input round-robin arbiter feeding a single registered output slot.
// A forced mode pins the grant to one channel without touching the
// round-robin pointer, so normal arbitration resumes where it left off.
module arb_mux_n #(
    parameter int WIDTH = 64,
    parameter int N     = 8,
    parameter int SW    = $clog2(N)
) (
    input  logic     clk,
    input  logic     reset,
    arb_mux_n_if.slave bus
);

    logic [SW-1:0]    r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_chan;

    logic             w_slot_free;
    logic [N-1:0]     w_hi_grant;
    logic [N-1:0]     w_lo_grant;
    logic [N-1:0]     w_rr_grant;
    logic [N-1:0]     w_force_grant;
    logic [N-1:0]     w_grant;
    logic             w_grant_any;
    logic [SW-1:0]    w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;
    logic [SW-1:0]    w_ptr_next;

    // The slot can take a new entry when empty or being drained this cycle.
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Round-robin search: lowest valid channel at or above the pointer,
    // otherwise wrap around to the lowest valid channel overall.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional write, so no path through the block infers a latch.
        w_hi_grant = '0;
        w_lo_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                w_lo_grant    = '0;
                w_lo_grant[i] = 1'b1;
                if (i >= int'(r_ptr)) begin
                    w_hi_grant    = '0;
                    w_hi_grant[i] = 1'b1;
                end
            end
        end
        w_rr_grant = (|w_hi_grant) ? w_hi_grant : w_lo_grant;
    end

    // Forced mode: only the selected channel, and only if it is valid;
    // an out-of-range select grants nothing.
    always_comb begin
        w_force_grant = '0;
        if (int'(bus.force_sel) < N) begin
            w_force_grant[bus.force_sel] = bus.in_valid[bus.force_sel];
        end
    end

    // Final one-hot grant; reset and a blocked slot suppress it entirely.
    always_comb begin
        w_grant = '0;
        if (!reset && w_slot_free) begin
            w_grant = bus.force_en ? w_force_grant : w_rr_grant;
        end
    end

    assign w_grant_any  = |w_grant;
    assign bus.in_ready = w_grant;

    // Encode the one-hot grant and select the granted channel's data.
    always_comb begin
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_grant_idx  = w_grant_idx | SW'(i);
                w_grant_data = w_grant_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves to the channel just after the winner, wrapping at N-1.
    assign w_ptr_next = (w_grant_idx == SW'(N - 1)) ? '0 : w_grant_idx + 1'b1;

    // Output slot and round-robin pointer state.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            // NOTE: out_data is reset too, because its post-reset value is
            // observable; wide datapath registers are often left unreset.
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else if (w_slot_free) begin
            if (w_grant_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_grant_data;
                r_out_chan  <= w_grant_idx;
                if (!bus.force_en) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_arb_mux_n;

    localparam int W  = 64;
    localparam int N  = 8;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic reset;
    logic reset6;

    always #5 clk = ~clk;

    arb_mux_n_if #(.WIDTH(W), .N(N),  .SW(3)) bus8 ();
    arb_mux_n_if #(.WIDTH(W), .N(N6), .SW(3)) bus6 ();

    arb_mux_n #(.WIDTH(W), .N(N), .SW(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    arb_mux_n #(.WIDTH(W), .N(N6), .SW(3)) u_dut6 (
        .clk   (clk),
        .reset (reset6),
        .bus   (bus6)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: one output slot plus the rotation pointer.
    logic [W-1:0] ch_data [N];
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_chan  = 0;
    int           m_ptr   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_data();
        for (int i = 0; i < N; i++) begin
            bus8.in_data[i*W +: W] = ch_data[i];
        end
    endtask

    // Channel the rules say wins this cycle, or -1 for no grant.
    function automatic int model_pick();
        logic [2:0] ci;
        int         s;
        if (reset) return -1;
        if (m_valid && !bus8.out_ready) return -1;
        if (bus8.force_en) begin
            s  = int'(bus8.force_sel);
            ci = 3'(s);
            if (s < N && bus8.in_valid[ci]) return s;
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            ci = 3'((m_ptr + k) % N);
            if (bus8.in_valid[ci]) return int'(ci);
        end
        return -1;
    endfunction

    // One clock: check in_ready, take the edge, advance the model, check outputs.
    task automatic cycle(input string tag);
        int g;
        bit rdy;
        bit fen;
        bit rst;
        logic [7:0] exp_ready;
        #1;
        g   = model_pick();
        rdy = bus8.out_ready;
        fen = bus8.force_en;
        rst = reset;
        exp_ready = (g >= 0) ? 8'(1 << g) : 8'h00;
        check({tag, ".in_ready"}, 64'(bus8.in_ready), 64'(exp_ready));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_ptr   = 0;
        end else if (!m_valid || rdy) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = ch_data[g];
                m_chan  = g;
                if (!fen) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check({tag, ".out_valid"}, 64'(bus8.out_valid), 64'(m_valid));
        check({tag, ".out_data"},  bus8.out_data,        m_data);
        check({tag, ".out_chan"},  64'(bus8.out_chan),   64'(m_chan));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle("reset");
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        reset6         = 1'b1;
        bus8.in_valid  = '0;
        bus8.force_en  = 1'b0;
        bus8.force_sel = '0;
        bus8.out_ready = 1'b0;
        bus6.in_data   = '0;
        bus6.in_valid  = '0;
        bus6.force_en  = 1'b0;
        bus6.force_sel = '0;
        bus6.out_ready = 1'b0;
        for (int i = 0; i < N; i++) ch_data[i] = {$urandom, $urandom};
        apply_data();
        @(negedge clk);

        // Reset with traffic present: no grant, everything cleared.
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b1;
        do_reset();

        // Single transfer from channel 0, one-cycle latency.
        ch_data[0] = 64'hA5;
        apply_data();
        bus8.in_valid = 8'h01;
        cycle("single");
        check("single.data_a5", bus8.out_data, 64'hA5);
        bus8.in_valid = 8'h00;
        cycle("single_idle");

        // All valid: strict rotation 0..7 then back to 0.
        do_reset();
        bus8.in_valid = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            cycle("rotate");
            check("rotate.seq", 64'(bus8.out_chan), 64'(k % N));
        end

        // Hold an entry from channel 3, then release: channel 4 wins next.
        do_reset();
        bus8.in_valid = 8'h08;
        cycle("hold_load");
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle("hold");
            check("hold.chan3", 64'(bus8.out_chan), 64'd3);
        end
        bus8.out_ready = 1'b1;
        #1;
        check("hold.next_ch4", 64'(bus8.in_ready), 64'h10);
        cycle("hold_release");

        // Forced mode: select 5, no fallback, pointer untouched.
        do_reset();
        bus8.force_en  = 1'b1;
        bus8.force_sel = 3'd5;
        bus8.in_valid  = 8'h21;
        cycle("force");
        check("force.chan5", 64'(bus8.out_chan), 64'd5);
        bus8.in_valid = 8'h01;
        cycle("force_none");
        check("force_none.valid", 64'(bus8.out_valid), 64'd0);
        bus8.force_en = 1'b0;
        bus8.in_valid = 8'hFF;
        #1;
        check("force.ptr_kept", 64'(bus8.in_ready), 64'h01);
        cycle("force_after");

        // Reset while an entry is held discards it and rewinds the pointer.
        do_reset();
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b1;
        cycle("prerst0");
        cycle("prerst1");
        bus8.out_ready = 1'b0;
        cycle("prerst_hold");
        reset = 1'b1;
        cycle("rst_held");
        check("rst_held.chan0", 64'(bus8.out_chan), 64'd0);
        reset = 1'b0;
        bus8.out_ready = 1'b1;
        #1;
        check("rst_held.first_ch0", 64'(bus8.in_ready), 64'h01);
        cycle("rst_after");

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) ch_data[i] = {$urandom, $urandom};
            apply_data();
            reset          = ($urandom_range(0, 49) == 0);
            bus8.in_valid  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            bus8.force_en  = ($urandom_range(0, 4) == 0);
            bus8.force_sel = 3'($urandom);
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            cycle("random");
        end
        reset = 1'b0;

        // Six-channel build with select 7: never any grant.
        @(negedge clk);
        reset6 = 1'b0;
        bus6.force_en  = 1'b1;
        bus6.force_sel = 3'd7;
        for (int n = 0; n < 20; n++) begin
            bus6.in_valid  = 6'($urandom) | 6'h01;
            bus6.out_ready = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N6; i++) bus6.in_data[i*W +: W] = {$urandom, $urandom};
            #1;
            check("n6.in_ready", 64'(bus6.in_ready), 64'd0);
            @(posedge clk);
            #1;
            check("n6.out_valid", 64'(bus6.out_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data bits per channel.
REQ-002 SHALL have parameter N, default 8, input channel count; legal range 2..16.
REQ-003 SHALL have parameter SW, default clog2(N), select/index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N*WIDTH  channel i at bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 SHALL have port in_valid  input  N  per-channel valid.
REQ-008 SHALL have port in_ready  output  N  per-channel accept; at most one bit high.
REQ-009 SHALL have port force_en  input  1  fixed-select mode enable.
REQ-010 SHALL have port force_sel  input  SW  channel selected when force_en=1.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed entry.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port out_chan  output  SW  source channel index of out_data.

Function
REQ-015 SHALL define input transfer on channel i as in_valid[i] & in_ready[i]; output transfer as out_valid & out_ready.
REQ-016 SHALL treat the output slot as free when !out_valid | out_ready; same-cycle drain and refill allowed.
REQ-017 SHALL, when slot free and force_en=1, grant force_sel only if in_valid[force_sel]=1; no fallback to other channels; force_sel >= N grants nothing.
REQ-018 SHALL, when slot free and force_en=0, grant the first valid channel searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-019 SHALL drive in_ready as the one-hot grant; all zero when slot not free or no channel eligible.
REQ-020 SHALL, on input transfer from channel g, load out_data <= in_data[g], out_chan <= g, out_valid <= 1 at the same edge; latency exactly 1 cycle.
REQ-021 SHALL, when slot free and no grant, clear out_valid at the edge; out_data and out_chan keep last values.
REQ-022 SHALL hold out_data, out_chan, out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL update ptr <= (g+1) mod N after a round-robin grant g; forced grants and no-grant cycles leave ptr unchanged.
REQ-024 SHALL sustain one transfer per cycle while out_ready=1 and any eligible channel valid.
REQ-025 SHALL, with all channels valid and out_ready=1, grant 0,1,...,N-1,0,... with no channel starved longer than N-1 grants.
REQ-026 SHALL apply force_en/force_sel changes only to the next grant; a held output entry is unaffected.

Reset
REQ-027 SHALL, on any rising edge with reset=1, set out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 SHALL force in_ready=0 while reset=1; reset overrides any simultaneous transfer and discards a held entry.

Verification (N=8, WIDTH=64)
REQ-029 SHALL cover: reset, then in_valid=8'h01, in_data[0]=64'hA5, out_ready=1 -> next cycle out_valid=1, out_data=64'hA5, out_chan=0.
REQ-030 SHALL cover: in_valid=8'hFF held, out_ready=1, force_en=0 -> out_chan sequence 0,1,...,7,0 on consecutive cycles.
REQ-031 SHALL cover: entry from channel 3 held with out_ready=0 for 5 cycles while other channels valid -> out_data/out_chan stable, in_ready=0; on out_ready=1 next grant is channel 4 same cycle.
REQ-032 SHALL cover: force_en=1, force_sel=5, in_valid=8'h21 -> only in_ready[5]=1, out_chan=5; in_valid=8'h01 -> no grant, out_valid drops; ptr unchanged.
REQ-033 SHALL cover: force_sel=7 with N=6 build, force_en=1 -> in_ready=0 forever, out_valid=0.
REQ-034 SHALL cover: reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_chan=0; after release, in_valid=8'hFF grants channel 0 first.
